// File: rtl/hack_mem_pkg.sv
// Shared types for the Hack memory-map RAM banks.
// Optional hardware clear is enabled with `define RAM_BANK_CLEAR_EN.
package hack_mem_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam int READ_FIRST  = 0;
    localparam int WRITE_FIRST = 1;

endpackage

// File: rtl/ram_bank_mem.sv
// Bare single-port array: sync write, registered read.
// No reset so synthesis can map it onto block RAM.
module ram_bank_mem
    import hack_mem_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int ADDR_W    = 8,
    parameter int READ_MODE = READ_FIRST
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [1<<ADDR_W];

    // Write port plus registered read; write-first forwards wdata.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            if (READ_MODE == WRITE_FIRST && we) begin
                rdata <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/ram_bank.sv
// Parametrised Hack RAM bank: FSM, write-port mux, read-valid pipe.
// `define RAM_BANK_CLEAR_EN to sweep all words to zero after reset.
module ram_bank
    import hack_mem_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int ADDR_W    = 8,
    parameter int READ_MODE = READ_FIRST
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] address,
    input  logic [WIDTH-1:0]  in,
    input  logic              load,
    input  logic              rd_en,
    output logic [WIDTH-1:0]  out,
    output logic              read_valid,
    output logic              ready
);

    logic              mem_we;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_wdata;
    logic [WIDTH-1:0]  mem_rdata;
    logic [WIDTH-1:0]  hold_q;
    logic              valid_q;
    logic              ready_q;

`ifdef RAM_BANK_CLEAR_EN
    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] clr_addr;
    logic [ADDR_W-1:0] clr_addr_nx;
    logic              clearing;

    // State and sweep-address registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
        end else begin
            state    <= state_nx;
            clr_addr <= clr_addr_nx;
        end
    end

    // Sweep one word per cycle; leave CLEAR after the last word.
    always_comb begin
        state_nx    = state;
        clr_addr_nx = clr_addr;
        clearing    = 1'b0;
        unique case (state)
            ST_CLEAR: begin
                clearing    = 1'b1;
                clr_addr_nx = clr_addr + 1'b1;
                if (clr_addr == '1) begin
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                state_nx = ST_RUN;
            end
        endcase
    end

    // Ready trails the state by one cycle, after the final clear write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= (state == ST_RUN);
        end
    end

    // Clear sweep owns the write port while it runs.
    always_comb begin
        mem_we    = clearing | (load & ready_q);
        mem_addr  = clearing ? clr_addr : address;
        mem_wdata = clearing ? '0 : in;
    end
`else
    // Without clear, ready rises on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    // Write port driven straight from the CPU side.
    always_comb begin
        mem_we    = load & ready_q;
        mem_addr  = address;
        mem_wdata = in;
    end
`endif

    assign mem_re = rd_en & ready_q;

    ram_bank_mem #(
        .WIDTH     (WIDTH),
        .ADDR_W    (ADDR_W),
        .READ_MODE (READ_MODE)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    // Valid pipe and held copy of the last returned word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            valid_q <= mem_re;
            if (valid_q) begin
                hold_q <= mem_rdata;
            end
        end
    end

    assign out        = valid_q ? mem_rdata : hold_q;
    assign read_valid = valid_q;
    assign ready      = ready_q;

endmodule

// File: tb/tb_ram_bank.sv
// Directed scoreboard bench for ram_bank (ADDR_W=8 read-first main
// instance, ADDR_W=4 write-first side instance on shared stimulus).
module tb_ram_bank;

    localparam int DEPTH = 256;
`ifdef RAM_BANK_CLEAR_EN
    localparam int  EXP_EDGES = DEPTH + 1;
    localparam int  WF_EDGES  = 17;
    localparam bit  CLR       = 1'b1;
`else
    localparam int  EXP_EDGES = 1;
    localparam int  WF_EDGES  = 1;
    localparam bit  CLR       = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  address;
    logic [15:0] din;
    logic        load;
    logic        rd_en;
    logic [15:0] out;
    logic        read_valid;
    logic        ready;
    logic [15:0] wf_out;
    logic        wf_valid;
    logic        wf_ready;

    logic [15:0] mem_m [DEPTH];
    logic [15:0] exp_q [$];
    logic [15:0] last_exp;
    int          vectors;
    int          miscompares;
    int          valid_seen;

    always #5 clk = ~clk;

    ram_bank #(
        .WIDTH     (16),
        .ADDR_W    (8),
        .READ_MODE (0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .address    (address),
        .in         (din),
        .load       (load),
        .rd_en      (rd_en),
        .out        (out),
        .read_valid (read_valid),
        .ready      (ready)
    );

    ram_bank #(
        .WIDTH     (16),
        .ADDR_W    (4),
        .READ_MODE (1)
    ) u_wf (
        .clk        (clk),
        .rst_n      (rst_n),
        .address    (address[3:0]),
        .in         (din),
        .load       (load),
        .rd_en      (rd_en),
        .out        (wf_out),
        .read_valid (wf_valid),
        .ready      (wf_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit ld, input bit rd,
                       input logic [7:0] a, input logic [15:0] d);
        bit          rdy;
        bit          ev;
        logic [15:0] e;
        address = a;
        din     = d;
        load    = ld;
        rd_en   = rd;
        rdy     = ready;
        ev      = rdy && rd;
        if (ev) exp_q.push_back(mem_m[a]);
        if (rdy && ld) mem_m[a] = d;
        @(posedge clk);
        #1;
        chk("read_valid", {31'd0, read_valid}, {31'd0, ev});
        if (ev) begin
            e        = exp_q.pop_front();
            last_exp = e;
            valid_seen++;
            chk("out", {16'd0, out}, {16'd0, e});
        end else begin
            chk("out_hold", {16'd0, out}, {16'd0, last_exp});
        end
        load  = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic after_release();
        exp_q.delete();
        last_exp = '0;
        if (CLR) begin
            for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        end
    endtask

    task automatic wait_ready();
        int k;
        int wfk;
        k   = 0;
        wfk = 0;
        for (int i = 1; i <= 600; i++) begin
            cyc(1'b1, 1'b1, 8'h10, 16'hDEAD);
            if (wf_ready && wfk == 0) wfk = i;
            if (ready) begin
                k = i;
                break;
            end
        end
        chk("ready_edges", k, EXP_EDGES);
        chk("wf_ready_edges", wfk, WF_EDGES);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        valid_seen  = 0;
        last_exp    = '0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        rst_n   = 1'b0;
        address = '0;
        din     = '0;
        load    = 1'b0;
        rd_en   = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_valid", {31'd0, read_valid}, 32'd0);
        chk("rst_out", {16'd0, out}, 32'd0);
        rst_n = 1'b1;
        after_release();

        // Loads/reads while not ready are dropped.
        wait_ready();

        if (CLR) begin
            for (int a = 0; a < DEPTH; a++) begin
                cyc(1'b0, 1'b1, 8'(a), 16'h0);
            end
        end

        cyc(1'b1, 1'b0, 8'h05, 16'hBEEF);
        cyc(1'b0, 1'b1, 8'h05, 16'h0);
        cyc(1'b0, 1'b0, 8'h00, 16'h0);

        cyc(1'b1, 1'b0, 8'h22, 16'h1111);
        cyc(1'b1, 1'b1, 8'h22, 16'h2222);
        chk("wf_same_valid", {31'd0, wf_valid}, 32'd1);
        chk("wf_same_addr", {16'd0, wf_out}, 32'h2222);
        cyc(1'b0, 1'b1, 8'h22, 16'h0);

        for (int a = 0; a < DEPTH; a++) begin
            cyc(1'b1, 1'b0, 8'(a), 16'(a) ^ 16'hA5A5);
        end
        valid_seen = 0;
        for (int a = 0; a < DEPTH; a++) begin
            cyc(1'b0, 1'b1, 8'(a), 16'h0);
        end
        chk("stream_count", valid_seen, DEPTH);
        cyc(1'b0, 1'b0, 8'h00, 16'h0);

        // Async reset with a read in flight.
        address = 8'h33;
        rd_en   = 1'b1;
        @(posedge clk);
        #2;
        rd_en = 1'b0;
        chk("pre_rst_valid", {31'd0, read_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_valid", {31'd0, read_valid}, 32'd0);
        chk("async_ready", {31'd0, ready}, 32'd0);
        chk("async_out", {16'd0, out}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        after_release();
        wait_ready();

        // Reset again partway through the sweep.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        after_release();
        for (int i = 0; i < 7; i++) begin
            cyc(1'b0, 1'b1, 8'h40, 16'h0);
        end
        rst_n = 1'b0;
        #1;
        chk("mid_valid", {31'd0, read_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        after_release();
        wait_ready();

        cyc(1'b0, 1'b1, 8'h05, 16'h0);
        cyc(1'b0, 1'b1, 8'h22, 16'h0);
        cyc(1'b0, 1'b1, 8'h80, 16'h0);
        cyc(1'b0, 1'b0, 8'h00, 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
